// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin scheduler that shares one 64-bit integer
// calculator among NUM_REQ requesters. It handles one transaction at a time.
// Divide or modulo by zero and the reserved op code are answered directly
// with an error response; the calculator is not used for them.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is a one-hot accept)
//   req_op / req_a / req_b   packed per-requester op code (3b) and operands (64b)
//   calc_start/op/a/b        start pulse and latched operands to the calculator
//   calc_done / calc_result  calculator completion pulse and result
//   rsp_valid / rsp_ready    response handshake
//   rsp_id/rsp_data/rsp_err  requester index, result, error flag
//
// Optional feature: define CALC_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles with an error response. When the macro is undefined, WAIT has no
// bound.
module calc_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_op,
  input  logic [64*NUM_REQ-1:0]   req_a,
  input  logic [64*NUM_REQ-1:0]   req_b,
  output logic                    calc_start,
  output logic [2:0]              calc_op,
  output logic [63:0]             calc_a,
  output logic [63:0]             calc_b,
  input  logic                    calc_done,
  input  logic [63:0]             calc_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_data,
  output logic                    rsp_err
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_MOD = 3'b110;
  localparam logic [OP_W-1:0] OP_RSV = 3'b111;

  // Stop elaboration when the parameter set is not usable.
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT < 1) begin : g_bad_param
    $error("calc_arbiter: illegal NUM_REQ/ID_W/TIMEOUT combination");
  end

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              calc_start_q, calc_start_d;
  logic [OP_W-1:0]   calc_op_q, calc_op_d;
  logic [DATA_W-1:0] calc_a_q, calc_a_d;
  logic [DATA_W-1:0] calc_b_q, calc_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_trap;

  // (base + off) mod NUM_REQ. Both operands are below NUM_REQ, so at most
  // one subtraction is needed.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[wrap_idx(rr_ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  // Operands of the winning requester, and its trap condition.
  always_comb begin
    sel_op   = req_op[32'(grant_idx)*OP_W +: OP_W];
    sel_a    = req_a[32'(grant_idx)*DATA_W +: DATA_W];
    sel_b    = req_b[32'(grant_idx)*DATA_W +: DATA_W];
    sel_trap = (sel_op == OP_RSV) ||
               (((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0));
  end

  // Next-state logic and the combinational accept pulse.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    calc_start_d = 1'b0;
    calc_op_d    = calc_op_q;
    calc_a_d     = calc_a_q;
    calc_b_d     = calc_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
`ifdef CALC_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Gating with rst keeps req_ready low while reset is asserted.
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          calc_op_d = sel_op;
          calc_a_d  = sel_a;
          calc_b_d  = sel_b;
          rsp_id_d  = grant_idx;
          rr_ptr_d  = wrap_idx(grant_idx, 1);
          if (sel_trap) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '1;
            state_d     = S_RESP;
          end else begin
            calc_start_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef CALC_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        if (calc_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = calc_result;
          state_d     = S_RESP;
`ifdef CALC_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // WAIT has run for TIMEOUT cycles without calc_done. A calc_done
          // that arrives later falls outside WAIT and is ignored.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '1;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      calc_start_q <= 1'b0;
      calc_op_q    <= '0;
      calc_a_q     <= '0;
      calc_b_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      calc_start_q <= calc_start_d;
      calc_op_q    <= calc_op_d;
      calc_a_q     <= calc_a_d;
      calc_b_q     <= calc_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // WAIT-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign calc_start = calc_start_q;
  assign calc_op    = calc_op_q;
  assign calc_a     = calc_a_q;
  assign calc_b     = calc_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Testbench for calc_arbiter. A transaction-level reference model predicts
// the grant, start pulse and response for every cycle. The bench also acts
// as the calculator, returning its result after a chosen delay.
module tb_calc_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 8;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op;
  logic [64*N-1:0] req_a;
  logic [64*N-1:0] req_b;
  logic            calc_start;
  logic [2:0]      calc_op;
  logic [63:0]     calc_a;
  logic [63:0]     calc_b;
  logic            calc_done;
  logic [63:0]     calc_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [63:0]     rsp_data;
  logic            rsp_err;

  calc_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .calc_start(calc_start), .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_done(calc_done), .calc_result(calc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Per-requester stimulus, packed onto the DUT buses.
  logic [N-1:0] s_valid;
  logic [N-1:0] p_valid;
  logic [2:0]   s_op [N];
  logic [63:0]  s_a  [N];
  logic [63:0]  s_b  [N];

  always_comb begin
    req_valid = s_valid;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3]  = s_op[i];
      req_a[64*i +: 64] = s_a[i];
      req_b[64*i +: 64] = s_b[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit gen_en, refill, rdy_rand, calc_en;
  int hold_lo;
  logic [N-1:0] granted;

  // Reference model: round-robin pointer plus the single outstanding transaction.
  int          m_ptr;
  bit          t_busy, t_trap;
  int          t_acc, t_delay, t_rsp_from;
  logic [2:0]  t_op;
  logic [63:0] t_a, t_b, t_data;
  logic [IDW-1:0] t_id;
  logic        t_err;

  int          dut_grants[$];
  int          rsp_ids[$];
  logic [63:0] last_data;
  logic        last_err;
  int          start_cnt, rsp_cnt, sc;
  int          rr_exp [5] = '{0, 1, 2, 3, 0};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behaviour of the shared calculator. Exponents for pow are taken from
  // b[5:0]; the stimulus keeps them small anyway.
  function automatic logic [63:0] calc_fn(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    logic [63:0] t;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a * b;
      3'b011: r = a / b;
      3'b100: begin
        r = 0; t = a;
        while (t >= 64'd10) begin t = t / 64'd10; r = r + 64'd1; end
      end
      3'b101: begin
        r = 64'd1;
        for (int i = 0; i < int'(b[5:0]); i++) r = r * a;
      end
      3'b110: r = a % b;
      default: r = ONES;
    endcase
    return r;
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
    s_op[i] = op; s_a[i] = a; s_b[i] = b; p_valid[i] = 1'b1;
  endtask

  task automatic new_req_rand(input int i);
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    s_op[i] = op;
    s_a[i]  = {$urandom, $urandom};
    if (op == 3'b101)                s_b[i] = 64'($urandom_range(0, 20));
    else if ($urandom_range(0, 3) == 0) s_b[i] = 64'd0;
    else                             s_b[i] = {$urandom, $urandom};
    s_valid[i] = 1'b1;
  endtask

  task automatic accept(input int g);
    t_busy = 1'b1; t_acc = cyc; t_id = IDW'(g);
    t_op = s_op[g]; t_a = s_a[g]; t_b = s_b[g];
    t_trap  = (t_op == 3'b111) || (((t_op == 3'b011) || (t_op == 3'b110)) && (t_b == 64'd0));
    t_delay = rdy_rand ? int'($urandom_range(1, 3)) : 1;
    if (t_trap) begin
      t_data = ONES; t_err = 1'b1; t_rsp_from = cyc + 1;
    end else if (!calc_en) begin
      t_data = ONES; t_err = 1'b1; t_rsp_from = cyc + 2 + TO;
    end else begin
      t_data = calc_fn(t_op, t_a, t_b); t_err = 1'b0; t_rsp_from = cyc + 2 + t_delay;
    end
    m_ptr = (g + 1) % N;
    granted[g] = 1'b1;
  endtask

  // Compares every DUT output for the current cycle against the model.
  task automatic monitor();
    logic [N-1:0] exp_rdy;
    bit found, exp_s, exp_v;
    int g, idx;
    exp_rdy = '0; found = 1'b0; g = 0;
    if (!t_busy) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_ptr + i) % N;
        if (!found && s_valid[idx]) begin found = 1'b1; g = idx; exp_rdy[idx] = 1'b1; end
      end
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);

    exp_s = t_busy && !t_trap && (cyc == t_acc + 1);
    check_eq("calc_start", 64'(calc_start), 64'(exp_s));
    if (calc_start) start_cnt++;
    if (exp_s) begin
      check_eq("calc_op", 64'(calc_op), 64'(t_op));
      check_eq("calc_a", calc_a, t_a);
      check_eq("calc_b", calc_b, t_b);
    end

    exp_v = t_busy && (cyc >= t_rsp_from);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    if (exp_v) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(t_id));
      check_eq("rsp_data", rsp_data, t_data);
      check_eq("rsp_err", 64'(rsp_err), 64'(t_err));
      if (rsp_ready) t_busy = 1'b0;
    end
    if (rsp_valid && rsp_ready) begin
      rsp_ids.push_back(int'(rsp_id)); last_data = rsp_data; last_err = rsp_err; rsp_cnt++;
    end

    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (found) accept(g);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          s_valid[i] = 1'b0; granted[i] = 1'b0;
          if (refill) begin
            s_op[i] = 3'b000; s_a[i] = 64'($urandom); s_b[i] = 64'($urandom); s_valid[i] = 1'b1;
          end
        end else if (p_valid[i]) begin
          s_valid[i] = 1'b1; p_valid[i] = 1'b0;
        end else if (gen_en && !s_valid[i] && $urandom_range(0, 3) == 0) begin
          new_req_rand(i);
        end
      end
      if (hold_lo > 0) begin rsp_ready = 1'b0; hold_lo--; end
      else rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      calc_done   = t_busy && !t_trap && calc_en && (cyc == t_acc + 1 + t_delay);
      calc_result = calc_done ? t_data : {$urandom, $urandom};
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = '0; p_valid = '0; granted = '0;
    calc_done = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_calc_start", 64'(calc_start), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_eq("rst_calc_op", 64'(calc_op), 64'd0);
    check_eq("rst_calc_a", calc_a, 64'd0);
    check_eq("rst_calc_b", calc_b, 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    t_busy = 1'b0; m_ptr = 0;
  endtask

  initial begin
    rst = 1'b1; s_valid = '0; p_valid = '0; granted = '0;
    for (int i = 0; i < N; i++) begin s_op[i] = '0; s_a[i] = '0; s_b[i] = '0; end
    calc_done = 1'b0; calc_result = '0; rsp_ready = 1'b0;
    gen_en = 0; refill = 0; rdy_rand = 0; calc_en = 1; hold_lo = 0;
    t_busy = 0; t_trap = 0; t_acc = 0; t_delay = 1; t_rsp_from = 0; m_ptr = 0;
    t_op = '0; t_a = '0; t_b = '0; t_data = '0; t_id = '0; t_err = 1'b0;
    last_data = '0; last_err = 1'b0; start_cnt = 0; rsp_cnt = 0; sc = 0;

    // Single request: 5 + 7 from requester 1.
    do_reset();
    dut_grants.delete(); rsp_ids.delete();
    set_req(1, 3'b000, 64'd5, 64'd7);
    run(6);
    check_eq("single_grant_cnt", 64'(dut_grants.size()), 64'd1);
    check_eq("single_grant", 64'(dut_grants[0]), 64'd1);
    check_eq("single_id", 64'(rsp_ids[0]), 64'd1);
    check_eq("single_data", last_data, 64'd12);
    check_eq("single_err", 64'(last_err), 64'd0);

    // All four requesters request continuously, so grants rotate.
    do_reset();
    dut_grants.delete(); rsp_ids.delete();
    for (int i = 0; i < N; i++) set_req(i, 3'b000, 64'($urandom), 64'($urandom));
    refill = 1; run(24); refill = 0; run(30);
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_grant", 64'(dut_grants[k]), 64'(rr_exp[k]));
      check_eq("rr_rsp_id", 64'(rsp_ids[k]), 64'(rr_exp[k]));
    end

    // Traps: div by zero, mod by zero, reserved op code.
    sc = start_cnt; rsp_ids.delete();
    set_req(2, 3'b011, 64'd100, 64'd0); run(4);
    check_eq("div0_err", 64'(last_err), 64'd1);
    check_eq("div0_data", last_data, ONES);
    set_req(2, 3'b110, 64'd100, 64'd0); run(4);
    check_eq("mod0_err", 64'(last_err), 64'd1);
    set_req(0, 3'b111, 64'd3, 64'd5); run(4);
    check_eq("rsv_err", 64'(last_err), 64'd1);
    check_eq("trap_no_start", 64'(start_cnt - sc), 64'd0);
    check_eq("trap_ids", 64'(rsp_ids.size() == 3 && rsp_ids[0] == 2 && rsp_ids[1] == 2 && rsp_ids[2] == 0), 64'd1);

    // Backpressure: rsp_ready is held low while requester 3 waits.
    do_reset();
    dut_grants.delete();
    set_req(0, 3'b010, 64'd3, 64'd9);
    set_req(3, 3'b001, 64'd50, 64'd8);
    hold_lo = 8;
    run(16);
    check_eq("bp_grant_cnt", 64'(dut_grants.size()), 64'd2);
    check_eq("bp_second", 64'(dut_grants[1]), 64'd3);

    // Reset while in WAIT, followed by a stray calc_done.
    do_reset();
    calc_en = 0;
    set_req(2, 3'b010, 64'd6, 64'd7);
    run(5);
    do_reset();
    calc_en = 1;
    @(posedge clk); #1; calc_done = 1'b1; calc_result = 64'h1234; rsp_ready = 1'b1;
    @(posedge clk); #1; calc_done = 1'b0;
    @(negedge clk);
    check_eq("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rw_rsp_data", rsp_data, 64'd0);
    check_eq("rw_calc_start", 64'(calc_start), 64'd0);
    run(3);
    dut_grants.delete();
    set_req(3, 3'b000, 64'd1, 64'd1);
    set_req(0, 3'b000, 64'd2, 64'd2);
    run(12);
    check_eq("rw_ptr_grant", 64'(dut_grants[0]), 64'd0);

`ifdef CALC_TIMEOUT_EN
    // The calculator never answers, so the request times out.
    do_reset();
    calc_en = 0; last_err = 1'b0; last_data = '0;
    set_req(1, 3'b000, 64'd1, 64'd2);
    run(TO + 6);
    calc_en = 1;
    check_eq("tmo_err", 64'(last_err), 64'd1);
    check_eq("tmo_data", last_data, ONES);
`endif

    // Random traffic with random backpressure and calculator delay.
    do_reset();
    gen_en = 1; rdy_rand = 1;
    run(800);
    gen_en = 0;
    run(80);
    rdy_rand = 0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
